// File: rtl/usb_bus_scheduler_if.sv
// ---------------------------------------------------------------------------
// usb_bus_scheduler_if
//
// Purpose:
//    Groups the FT232H bridge bus (data register access, stall and the two
//    FIFO fill counters) into one bundle so the scheduler and the bridge
//    connect through a single port.
//
// Parameters:
//    CNT_W           width of usb_rxbytes / usb_txspace
//
// Signals:
//    usb_address     scheduler -> bridge, register select (always data reg)
//    usb_read        scheduler -> bridge, read strobe
//    usb_readdata    bridge -> scheduler, read data
//    usb_read_valid  bridge -> scheduler, read data return strobe
//    usb_write       scheduler -> bridge, write strobe
//    usb_writedata   scheduler -> bridge, write data
//    usb_waitreq     bridge -> scheduler, stall for read/write strobes
//    usb_rxbytes     bridge -> scheduler, bytes waiting in the RX FIFO
//    usb_txspace     bridge -> scheduler, free bytes in the TX FIFO
//
// Modports:
//    master          the scheduler side
//    slave           the bridge side
// ---------------------------------------------------------------------------
interface usb_bus_scheduler_if #(
   parameter int CNT_W = 9
);
   logic [1:0]       usb_address;
   logic             usb_read;
   logic [7:0]       usb_readdata;
   logic             usb_read_valid;
   logic             usb_write;
   logic [7:0]       usb_writedata;
   logic             usb_waitreq;
   logic [CNT_W-1:0] usb_rxbytes;
   logic [CNT_W-1:0] usb_txspace;

   modport master (
      output usb_address,
      output usb_read,
      output usb_write,
      output usb_writedata,
      input  usb_readdata,
      input  usb_read_valid,
      input  usb_waitreq,
      input  usb_rxbytes,
      input  usb_txspace
   );

   modport slave (
      input  usb_address,
      input  usb_read,
      input  usb_write,
      input  usb_writedata,
      output usb_readdata,
      output usb_read_valid,
      output usb_waitreq,
      output usb_rxbytes,
      output usb_txspace
   );
endinterface

// File: rtl/usb_bus_scheduler.sv
// ---------------------------------------------------------------------------
// usb_bus_scheduler
//
// Purpose:
//    Shares the single FT232H bridge bus between command-byte reads (host to
//    control decoder) and image-byte writes (formatter to host). Bursts are
//    served round-robin; each burst is bounded by BURST_MAX and by the
//    bridge's rxbytes/txspace count captured when the burst starts.
//    Everything runs in the clk_100M domain.
//
// Parameters:
//    BURST_MAX   max bytes per burst (1..255)
//    CNT_W       width of the bridge FIFO counters
//    TIMEOUT     read-return timeout in cycles (only with the watchdog)
//
// Optional feature:
//    `define USB_SCHED_TIMEOUT_EN builds a read-return watchdog. Without it
//    RD_WAIT waits forever and rd_timeout is tied low.
//
// Ports:
//    clk_100M      in   system clock
//    nrst          in   synchronous active-low reset
//    rx_ready      in   consumer can take a burst (looked at in IDLE only)
//    rx_valid      out  one-cycle pulse, rx_data holds a command byte
//    rx_data       out  received command byte
//    tx_valid      in   formatter has a byte on tx_data
//    tx_data       in   byte to send
//    tx_ready      out  byte taken when tx_valid & tx_ready
//    usb           bridge bus (master modport)
//    busy          out  high whenever a burst is in progress
//    rd_timeout    out  sticky read-timeout flag
// ---------------------------------------------------------------------------
module usb_bus_scheduler #(
   parameter int BURST_MAX = 16,
   parameter int CNT_W     = 9,
   parameter int TIMEOUT   = 64
) (
   input  logic                clk_100M,
   input  logic                nrst,
   input  logic                rx_ready,
   output logic                rx_valid,
   output logic [7:0]          rx_data,
   input  logic                tx_valid,
   input  logic [7:0]          tx_data,
   output logic                tx_ready,
   usb_bus_scheduler_if.master usb,
   output logic                busy,
   output logic                rd_timeout
);

   localparam int REM_W = $clog2(BURST_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_LOAD,
      WR_REQ
   } schedState_t;

   schedState_t      r_state;
   logic             r_lastWasTx;
   logic [REM_W-1:0] r_rem;
   logic             r_rxValid;
   logic [7:0]       r_rxData;
   logic             r_txReady;
   logic             r_usbRead;
   logic             r_usbWrite;
   logic [7:0]       r_usbWriteData;
   logic             r_busy;

   logic             w_rxPend;
   logic             w_txPend;
   logic [REM_W-1:0] w_rxBurst;
   logic [REM_W-1:0] w_txBurst;

`ifdef USB_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]  r_timeoutCnt;
   logic             r_rdTimeout;
`endif

   // Work out which side has something to do and how long its burst would
   // be if it started this cycle. The burst length is the smaller of the
   // bridge's FIFO count and BURST_MAX, so the remaining-byte counter is
   // never loaded with more than it can hold and never starts at zero.
   always_comb begin
      w_rxPend  = (usb.usb_rxbytes != '0) && rx_ready;
      w_txPend  = (usb.usb_txspace != '0) && tx_valid;
      w_rxBurst = REM_W'(BURST_MAX);
      w_txBurst = REM_W'(BURST_MAX);
      if (int'(usb.usb_rxbytes) < BURST_MAX) begin
         w_rxBurst = REM_W'(usb.usb_rxbytes);
      end
      if (int'(usb.usb_txspace) < BURST_MAX) begin
         w_txBurst = REM_W'(usb.usb_txspace);
      end
   end

   // The scheduler FSM. Every output is a register updated together with
   // the state, so outputs always match the state they belong to. A burst
   // always drops back through IDLE for one cycle, which is where the
   // round-robin decision is made: when both sides are pending the side
   // that was not served last wins. After reset last-served is TX so the
   // first tie goes to RX. Reads keep only one request outstanding; the
   // remaining-byte counter is decremented on each completed byte and the
   // burst ends on the byte that takes it from one to zero.
   always_ff @(posedge clk_100M) begin
      if (!nrst) begin
         r_state        <= IDLE;
         r_lastWasTx    <= 1'b1;
         r_rem          <= '0;
         r_rxValid      <= 1'b0;
         r_rxData       <= '0;
         r_txReady      <= 1'b0;
         r_usbRead      <= 1'b0;
         r_usbWrite     <= 1'b0;
         r_usbWriteData <= '0;
         r_busy         <= 1'b0;
`ifdef USB_SCHED_TIMEOUT_EN
         r_timeoutCnt   <= '0;
         r_rdTimeout    <= 1'b0;
`endif
      end else begin
         r_rxValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rxPend && (!w_txPend || r_lastWasTx)) begin
                  r_rem     <= w_rxBurst;
                  r_usbRead <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= RD_REQ;
               end else if (w_txPend) begin
                  r_rem     <= w_txBurst;
                  r_txReady <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= WR_LOAD;
               end
            end

            RD_REQ: begin
               if (!usb.usb_waitreq) begin
                  r_usbRead <= 1'b0;
                  r_state   <= RD_WAIT;
`ifdef USB_SCHED_TIMEOUT_EN
                  r_timeoutCnt <= '0;
`endif
               end
            end

            RD_WAIT: begin
               if (usb.usb_read_valid) begin
                  r_rxData  <= usb.usb_readdata;
                  r_rxValid <= 1'b1;
                  r_rem     <= r_rem - REM_W'(1);
                  if (r_rem == REM_W'(1)) begin
                     r_busy      <= 1'b0;
                     r_lastWasTx <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_usbRead <= 1'b1;
                     r_state   <= RD_REQ;
                  end
               end
`ifdef USB_SCHED_TIMEOUT_EN
               else if (r_timeoutCnt == TO_W'(TIMEOUT - 1)) begin
                  r_rdTimeout <= 1'b1;
                  r_busy      <= 1'b0;
                  r_lastWasTx <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_timeoutCnt <= r_timeoutCnt + TO_W'(1);
               end
`endif
            end

            WR_LOAD: begin
               r_txReady <= 1'b0;
               if (tx_valid) begin
                  r_usbWriteData <= tx_data;
                  r_usbWrite     <= 1'b1;
                  r_state        <= WR_REQ;
               end else begin
                  // An idle formatter ends its burst so it cannot starve RX.
                  r_busy      <= 1'b0;
                  r_lastWasTx <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            WR_REQ: begin
               if (!usb.usb_waitreq) begin
                  r_usbWrite <= 1'b0;
                  r_rem      <= r_rem - REM_W'(1);
                  if (r_rem == REM_W'(1)) begin
                     r_busy      <= 1'b0;
                     r_lastWasTx <= 1'b1;
                     r_state     <= IDLE;
                  end else begin
                     r_txReady <= 1'b1;
                     r_state   <= WR_LOAD;
                  end
               end
            end

            default: begin
               r_usbRead  <= 1'b0;
               r_usbWrite <= 1'b0;
               r_txReady  <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // Drive the ports from their registers; the bridge address is fixed to
   // the data register.
   assign rx_valid          = r_rxValid;
   assign rx_data           = r_rxData;
   assign tx_ready          = r_txReady;
   assign busy              = r_busy;
   assign usb.usb_address   = 2'd0;
   assign usb.usb_read      = r_usbRead;
   assign usb.usb_write     = r_usbWrite;
   assign usb.usb_writedata = r_usbWriteData;

`ifdef USB_SCHED_TIMEOUT_EN
   assign rd_timeout = r_rdTimeout;
`else
   // No watchdog in this build: the flag is constant low. TIMEOUT is folded
   // in only so the parameter stays referenced; the term is always zero.
   assign rd_timeout = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_usb_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_usb_bus_scheduler
//
// Randomised bench for usb_bus_scheduler. The bench plays the FT232H bridge
// (random stalls, random read latency, random FIFO counts), the command
// consumer and the image formatter. A burst-level model predicts, each time
// the scheduler sits in IDLE, which side it should serve next and how many
// bytes that burst must move; byte streams are checked through queues.
// ---------------------------------------------------------------------------
module tb_usb_bus_scheduler;

   localparam int BURST_MAX = 16;
   localparam int CNT_W     = 9;
   localparam int TIMEOUT   = 64;

   logic       clk_100M = 1'b0;
   logic       nrst;
   logic       rx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       rd_timeout;

   usb_bus_scheduler_if #(.CNT_W(CNT_W)) usb ();

   usb_bus_scheduler #(
      .BURST_MAX (BURST_MAX),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk_100M   (clk_100M),
      .nrst       (nrst),
      .rx_ready   (rx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .usb        (usb),
      .busy       (busy),
      .rd_timeout (rd_timeout)
   );

   // 100 MHz clock.
   always #5 clk_100M = ~clk_100M;

   int         vectorCount;
   int         missCount;

   // Byte streams: what the bridge returned and what the formatter handed over.
   logic [7:0] rxExp[$];
   logic [7:0] txExp[$];

   // Burst-level model state.
   bit         modelLastTx;
   bit         prevIdle;
   bit         expStart;
   bit         burstActive;
   bit         expIsTx;
   int         expLen;
   int         nReads;
   int         nWrites;
   int         nBursts;

   // Bridge and formatter state.
   bit         rdOutstanding;
   int         rdDelay;
   int         stallLeft;
   bit         txTaken;
   logic [7:0] curTx;
   int         txAvail;
   bit         prevWrHeld;
   logic [7:0] prevWrData;

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int minOf(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Forget everything the bench was tracking; used after every reset.
   task automatic clearModel();
      rxExp.delete();
      txExp.delete();
      rdOutstanding = 1'b0;
      burstActive   = 1'b0;
      prevIdle      = 1'b0;
      prevWrHeld    = 1'b0;
      modelLastTx   = 1'b1;
      txTaken       = 1'b1;
      txAvail       = 0;
      stallLeft     = 0;
   endtask

   // Hold reset for one edge, check every output is low, then release. With
   // strayValid a read return arrives right after reset and must be ignored.
   task automatic applyReset(input bit strayValid);
      @(negedge clk_100M);
      nrst               = 1'b0;
      rx_ready           = 1'b0;
      tx_valid           = 1'b0;
      tx_data            = 8'h00;
      usb.usb_waitreq    = 1'b0;
      usb.usb_read_valid = 1'b0;
      usb.usb_readdata   = 8'h00;
      usb.usb_rxbytes    = '0;
      usb.usb_txspace    = '0;
      @(negedge clk_100M);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_rx_valid", rx_valid, 0);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_tx_ready", tx_ready, 0);
      checkOutput("rst_usb_read", usb.usb_read, 0);
      checkOutput("rst_usb_write", usb.usb_write, 0);
      checkOutput("rst_usb_wdata", usb.usb_writedata, 0);
      checkOutput("rst_rd_timeout", rd_timeout, 0);
      nrst = 1'b1;
      if (strayValid) begin
         usb.usb_read_valid = 1'b1;
         usb.usb_readdata   = 8'hA5;
      end
      @(negedge clk_100M);
      checkOutput("post_rst_rx_valid", rx_valid, 0);
      checkOutput("post_rst_busy", busy, 0);
      usb.usb_read_valid = 1'b0;
      clearModel();
   endtask

   // One random cycle: check what the DUT shows, drive new inputs, account
   // for the handshakes that will complete at the coming edge, and let the
   // model decide the next burst whenever the scheduler is idle.
   task automatic applyStimulus();
      logic       sRead, sWrite, sRxValid, sTxReady, sBusy;
      logic [7:0] sWrData, sRxData;
      int         rxCnt, txCnt;
      bit         rxPend, txPend;

      @(negedge clk_100M);
      sRead    = usb.usb_read;
      sWrite   = usb.usb_write;
      sWrData  = usb.usb_writedata;
      sRxValid = rx_valid;
      sRxData  = rx_data;
      sTxReady = tx_ready;
      sBusy    = busy;

      checkOutput("address", usb.usb_address, 0);
      checkOutput("rd_timeout", rd_timeout, 0);
      if (prevIdle) checkOutput("burst_start", sBusy, expStart);

      if (sRxValid) begin
         if (rxExp.size() == 0) checkOutput("rx_extra", 1, 0);
         else checkOutput("rx_data", sRxData, rxExp.pop_front());
      end

      if (!sBusy && burstActive) begin
         burstActive = 1'b0;
         nBursts++;
         if (expIsTx) begin
            checkOutput("tx_len", nWrites, expLen);
            checkOutput("tx_no_reads", nReads, 0);
         end else begin
            checkOutput("rx_len", nReads, expLen);
            checkOutput("rx_no_writes", nWrites, 0);
            checkOutput("rx_drained", rxExp.size(), 0);
         end
      end

      if (prevWrHeld) begin
         checkOutput("wr_held", sWrite, 1);
         checkOutput("wr_data_held", sWrData, prevWrData);
      end

      // Bridge stall: mostly random, with occasional 5-cycle stalls.
      if (stallLeft > 0) begin
         usb.usb_waitreq = 1'b1;
         stallLeft--;
      end else if ($urandom_range(0, 40) == 0) begin
         usb.usb_waitreq = 1'b1;
         stallLeft = 4;
      end else begin
         usb.usb_waitreq = ($urandom_range(0, 9) < 3);
      end

      usb.usb_rxbytes = ($urandom_range(0, 3) == 0) ? '0 :
                        ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(1, 511)) :
                                                      CNT_W'($urandom_range(1, 24));
      usb.usb_txspace = ($urandom_range(0, 3) == 0) ? '0 :
                        ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(1, 511)) :
                                                      CNT_W'($urandom_range(1, 24));
      rx_ready = ($urandom_range(0, 3) != 0);

      if (sRead) checkOutput("single_read", rdOutstanding, 0);

      usb.usb_read_valid = 1'b0;
      usb.usb_readdata   = 8'($urandom);
      if (rdOutstanding) begin
         if (rdDelay == 0) begin
            usb.usb_read_valid = 1'b1;
            rxExp.push_back(usb.usb_readdata);
            rdOutstanding = 1'b0;
         end else begin
            rdDelay--;
         end
      end

      // Formatter: refills its supply only while the scheduler is idle.
      if (!sBusy && $urandom_range(0, 3) == 0) txAvail = $urandom_range(0, 20);
      if (txTaken) begin
         curTx   = 8'($urandom);
         txTaken = 1'b0;
      end
      tx_valid = (txAvail > 0);
      tx_data  = curTx;

      if (sRead && !usb.usb_waitreq) begin
         rdOutstanding = 1'b1;
         rdDelay       = $urandom_range(0, 3);
         if (burstActive) nReads++;
         else checkOutput("stray_read", 1, 0);
      end

      if (sWrite && !usb.usb_waitreq) begin
         if (txExp.size() == 0) checkOutput("wr_extra", 1, 0);
         else checkOutput("wr_data", sWrData, txExp.pop_front());
         if (burstActive) nWrites++;
         else checkOutput("stray_write", 1, 0);
      end
      prevWrHeld = sWrite && usb.usb_waitreq;
      prevWrData = sWrData;

      if (tx_valid && sTxReady) begin
         txExp.push_back(curTx);
         txAvail--;
         txTaken = 1'b1;
      end

      // Round-robin model, evaluated on the inputs seen in the idle cycle.
      prevIdle = !sBusy;
      if (!sBusy) begin
         rxCnt    = int'(usb.usb_rxbytes);
         txCnt    = int'(usb.usb_txspace);
         rxPend   = (rxCnt != 0) && rx_ready;
         txPend   = (txCnt != 0) && tx_valid;
         expStart = rxPend || txPend;
         if (expStart) begin
            if (rxPend && txPend) expIsTx = !modelLastTx;
            else expIsTx = txPend;
            expLen = expIsTx ? minOf(minOf(txCnt, BURST_MAX), txAvail)
                             : minOf(rxCnt, BURST_MAX);
            modelLastTx = expIsTx;
            burstActive = 1'b1;
            nReads      = 0;
            nWrites     = 0;
         end
      end
   endtask

`ifdef USB_SCHED_TIMEOUT_EN
   // A read that never returns must abort after TIMEOUT cycles in RD_WAIT
   // and leave a flag that only reset clears.
   task automatic timeoutTest();
      int busyCycles;
      applyReset(1'b0);
      usb.usb_rxbytes = CNT_W'(5);
      rx_ready        = 1'b1;
      busyCycles      = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_100M);
         if (busy) busyCycles++;
         else if (busyCycles > 0) break;
      end
      usb.usb_rxbytes = '0;
      rx_ready        = 1'b0;
      checkOutput("to_flag", rd_timeout, 1);
      checkOutput("to_cycles", busyCycles, 1 + TIMEOUT);
      @(negedge clk_100M);
      checkOutput("to_sticky", rd_timeout, 1);
      checkOutput("to_idle", busy, 0);
      applyReset(1'b0);
   endtask
`endif

   // Main sequence: reset, random traffic, a reset in the middle of a
   // burst, more random traffic, then the optional watchdog check.
   initial begin
      vectorCount        = 0;
      missCount          = 0;
      nBursts            = 0;
      nrst               = 1'b0;
      rx_ready           = 1'b0;
      tx_valid           = 1'b0;
      tx_data            = 8'h00;
      curTx              = 8'h00;
      prevWrData         = 8'h00;
      rdDelay            = 0;
      expLen             = 0;
      nReads             = 0;
      nWrites            = 0;
      expStart           = 1'b0;
      expIsTx            = 1'b0;
      usb.usb_waitreq    = 1'b0;
      usb.usb_read_valid = 1'b0;
      usb.usb_readdata   = 8'h00;
      usb.usb_rxbytes    = '0;
      usb.usb_txspace    = '0;
      clearModel();

      applyReset(1'b0);
      for (int i = 0; i < 3000; i++) applyStimulus();

      for (int i = 0; i < 200 && !burstActive; i++) applyStimulus();
      applyStimulus();
      applyStimulus();
      applyReset(1'b1);

      for (int i = 0; i < 3000; i++) applyStimulus();
      checkOutput("bursts_seen", (nBursts > 100), 1);

`ifdef USB_SCHED_TIMEOUT_EN
      timeoutTest();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
